// File: rtl/nfc_page_reader.sv
// Source-side NAND page reader: resets flash A, then per request issues READ plus three
// address cycles, waits for ready/busy and streams the 512-byte page over valid/ready.
module nfc_page_reader #(
   parameter int unsigned PAGE_BITS  = 9,
   parameter int unsigned PAGE_SIZE  = 512,
   parameter int unsigned TWB_CYCLES = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic [PAGE_BITS-1:0] page_addr_i,
   output logic                 busy_o,
   output logic [7:0]           rd_data_o,
   output logic                 rd_valid_o,
   input  logic                 rd_ready_i,
   output logic                 rd_last_o,
   output logic                 page_done_o,
   inout  wire  [7:0]           f_io_a_io,
   output logic                 f_cle_a_o,
   output logic                 f_ale_a_o,
   output logic                 f_ren_a_o,
   output logic                 f_wen_a_o,
   input  logic                 f_rb_a_i
);

   localparam int unsigned CntW = $clog2(TWB_CYCLES + 3);

   typedef enum logic [3:0] {
      StInitCmd, StInitWait, StIdle, StCmd, StAddr0, StAddr1, StAddr2,
      StWaitTwb, StWaitRb, StRdLo, StRdHi, StHold, StDone
   } state_e;

   state_e               state_q, state_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic [9:0]           byte_cnt_q, byte_cnt_d;
   logic [PAGE_BITS-1:0] page_q, page_d;
   logic [7:0]           rd_data_q, rd_data_d;
   logic                 io_oe;
   logic [7:0]           io_out;
   logic [15:0]          page_ext;
   logic                 last_byte;

   assign page_ext  = 16'(page_q);
   assign last_byte = (byte_cnt_q == 10'(PAGE_SIZE - 1));
   assign f_io_a_io = io_oe ? io_out : 8'hzz;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= StInitCmd;
         cnt_q      <= '0;
         byte_cnt_q <= '0;
         page_q     <= '0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         byte_cnt_q <= byte_cnt_d;
         page_q     <= page_d;
         rd_data_q  <= rd_data_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      byte_cnt_d  = byte_cnt_q;
      page_d      = page_q;
      rd_data_d   = rd_data_q;
      io_oe       = 1'b0;
      io_out      = 8'h00;
      f_cle_a_o   = 1'b0;
      f_ale_a_o   = 1'b0;
      f_ren_a_o   = 1'b1;
      f_wen_a_o   = 1'b1;
      busy_o      = 1'b1;
      page_done_o = 1'b0;

      unique case (state_q)
         // cnt 0 is an idle cycle so the bus stays quiet while rst is held
         StInitCmd: begin
            if (cnt_q != '0) begin
               io_oe     = 1'b1;
               io_out    = 8'hFF;
               f_cle_a_o = 1'b1;
               f_wen_a_o = (cnt_q != CntW'(1));
            end
            if (cnt_q == CntW'(2)) begin
               cnt_d   = '0;
               state_d = StInitWait;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StInitWait: begin
            if (cnt_q < CntW'(TWB_CYCLES)) begin
               cnt_d = cnt_q + CntW'(1);
            end else if (f_rb_a_i) begin
               cnt_d   = '0;
               state_d = StIdle;
            end
         end
         StIdle: begin
            busy_o = 1'b0;
            if (start_i) begin
               page_d  = page_addr_i;
               cnt_d   = '0;
               state_d = StCmd;
            end
         end
         StCmd, StAddr0, StAddr1, StAddr2: begin
            io_oe     = 1'b1;
            f_wen_a_o = (cnt_q != '0);
            f_cle_a_o = (state_q == StCmd);
            f_ale_a_o = (state_q != StCmd);
            if (state_q == StCmd) byte_cnt_d = '0;
            case (state_q)
               StAddr1: io_out = page_ext[7:0];
               StAddr2: io_out = page_ext[15:8];
               default: io_out = 8'h00;
            endcase
            if (cnt_q == '0) begin
               cnt_d = CntW'(1);
            end else begin
               cnt_d = '0;
               case (state_q)
                  StCmd:   state_d = StAddr0;
                  StAddr0: state_d = StAddr1;
                  StAddr1: state_d = StAddr2;
                  default: state_d = StWaitTwb;
               endcase
            end
         end
         StWaitTwb: begin
            if (cnt_q == CntW'(TWB_CYCLES - 1)) begin
               cnt_d   = '0;
               state_d = StWaitRb;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StWaitRb: begin
            if (f_rb_a_i) begin
               cnt_d   = '0;
               state_d = StRdLo;
            end
         end
         StRdLo: begin
            f_ren_a_o = 1'b0;
            if (cnt_q == '0) begin
               cnt_d = CntW'(1);
            end else begin
               cnt_d     = '0;
               rd_data_d = f_io_a_io;
               state_d   = StRdHi;
            end
         end
         StRdHi, StHold: begin
            if (rd_ready_i) begin
               byte_cnt_d = byte_cnt_q + 10'd1;
               state_d    = last_byte ? StDone : StRdLo;
            end else begin
               state_d = StHold;
            end
         end
         StDone: begin
            page_done_o = 1'b1;
            state_d     = StIdle;
         end
         default: state_d = StInitCmd;
      endcase
   end

   assign rd_valid_o = (state_q == StRdHi) || (state_q == StHold);
   assign rd_last_o  = rd_valid_o && last_byte;
   assign rd_data_o  = rd_data_q;

endmodule

// File: tb/tb_nfc_page_reader.sv
// Bench for nfc_page_reader: behavioural flash A model plus a byte scoreboard fed at start.
module tb_nfc_page_reader;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [8:0] page_addr = '0;
   logic       busy, rd_valid, rd_last, page_done, rd_ready = 1'b0;
   logic [7:0] rd_data;
   wire  [7:0] f_io;
   logic       f_cle, f_ale, f_ren, f_wen, f_rb;

   int vectors = 0;
   int errors  = 0;

   logic [7:0] exp_q[$];
   logic [7:0] obs_data[$];
   logic       obs_last[$];
   logic [9:0] bus_q[$];   // {cle, ale, io} at each WEN rise

   always #5 clk = ~clk;

   nfc_page_reader #(.PAGE_BITS(9), .PAGE_SIZE(512), .TWB_CYCLES(2)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .page_addr_i(page_addr), .busy_o(busy),
      .rd_data_o(rd_data), .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_last_o(rd_last),
      .page_done_o(page_done), .f_io_a_io(f_io), .f_cle_a_o(f_cle), .f_ale_a_o(f_ale),
      .f_ren_a_o(f_ren), .f_wen_a_o(f_wen), .f_rb_a_i(f_rb)
   );

   function automatic logic [7:0] flash_byte(input int unsigned a);
      return 8'((a * 37) ^ (a >> 8) ^ 32'h5A);
   endfunction

   // Flash A model
   int         fl_busy = 0;
   int         fl_addr_n = 0;
   int unsigned fl_ptr = 0;
   logic [7:0] fl_a0 = 0, fl_a1 = 0;
   logic       wen_prev = 1'b1, ren_prev = 1'b1;
   int         viol = 0;

   assign f_rb = (fl_busy == 0);
   assign f_io = (f_ren == 1'b0) ? flash_byte(fl_ptr) : 8'hzz;

   always @(negedge clk) begin
      if (fl_busy > 0) fl_busy <= fl_busy - 1;
      if ((f_cle && f_ale) || (!f_ren && !f_wen)) viol <= viol + 1;
      if (!ren_prev && f_ren) fl_ptr <= fl_ptr + 1;
      if (!wen_prev && f_wen) begin
         bus_q.push_back({f_cle, f_ale, f_io});
         if (f_cle) begin
            fl_addr_n <= 0;
            if (f_io == 8'hFF) fl_busy <= 15;
         end else if (f_ale) begin
            fl_addr_n <= fl_addr_n + 1;
            if (fl_addr_n == 0) fl_a0 <= f_io;
            if (fl_addr_n == 1) fl_a1 <= f_io;
            if (fl_addr_n == 2) begin
               fl_ptr  <= ({23'd0, f_io[0], fl_a1} * 512) + {24'd0, fl_a0};
               fl_busy <= 25;
            end
         end
      end
      wen_prev <= f_wen;
      ren_prev <= f_ren;
   end

   task automatic wait_idle(output int cycles, output bit pd_seen);
      cycles = 0; pd_seen = 0;
      while (busy !== 1'b0 && cycles < 500) begin
         @(negedge clk);
         cycles++;
         if (page_done) pd_seen = 1;
      end
   endtask

   task automatic issue_start(input int unsigned p);
      int cyc = 0;
      while (busy !== 1'b0 && cyc < 500) begin @(negedge clk); cyc++; end
      page_addr = 9'(p);
      start = 1'b1;
      for (int c = 0; c < 512; c++) exp_q.push_back(flash_byte(p * 512 + c));
      @(negedge clk);
      start = 1'b0;
   endtask

   // Consumes bytes until page_done; optional stall, stray start pulse or reset at a byte index.
   task automatic collect(input int stall_at, input int stall_len, input int start_at,
                          input int rst_at, output int n_done, output int stall_bad,
                          output bit timed_out);
      int         held = 0;
      int         cyc = 0;
      bit         pulsed = 0;
      logic [7:0] hold_data = '0;
      n_done = 0; stall_bad = 0; timed_out = 0;
      obs_data.delete();
      obs_last.delete();
      while (n_done == 0) begin
         @(negedge clk);
         start = 1'b0;
         cyc++;
         if (cyc > 5000) begin timed_out = 1; break; end
         if (page_done) begin n_done++; break; end
         if (obs_data.size() == rst_at) begin rst = 1'b1; break; end
         if (!pulsed && obs_data.size() == start_at && rd_valid) begin
            start = 1'b1; page_addr = 9'h1AA; pulsed = 1;
         end
         rd_ready = 1'b1;
         if (obs_data.size() == stall_at && rd_valid && held < stall_len) begin
            if (held == 0) hold_data = rd_data;
            else if (rd_data !== hold_data) stall_bad++;
            if (f_ren !== 1'b1) stall_bad++;
            rd_ready = 1'b0;
            held++;
         end
         if (rd_valid && rd_ready) begin
            obs_data.push_back(rd_data);
            obs_last.push_back(rd_last);
         end
      end
   endtask

   task automatic test_reset();
      int cycles; bit pd;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      vectors++;
      if ({f_cle, f_ale, f_ren, f_wen, busy, rd_valid, rd_last, page_done, rd_data} !==
          {8'b0011_1000, 8'h00})
         begin errors++; $display("FAIL reset_values got %b", {f_cle, f_ale, f_ren, f_wen,
                busy, rd_valid, rd_last, page_done, rd_data}); end
      bus_q.delete();
      rst = 1'b0;
      wait_idle(cycles, pd);
      vectors++;
      if (bus_q.size() != 1 || bus_q[0] !== 10'h2FF) begin
         errors++;
         $display("FAIL init_cmd got %0d writes first %h want 1 write 2ff", bus_q.size(),
                  bus_q.size() > 0 ? bus_q[0] : 10'h0);
      end
      vectors++;
      if (cycles < 15 || f_rb !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL init_busy idle after %0d cycles rb=%b busy=%b want >=15 rb=1 busy=0",
                  cycles, f_rb, busy);
      end
   endtask

   task automatic test_page(input int unsigned p, input int stall_at, input int start_at);
      int n_done, stall_bad, nlast; bit to;
      logic [7:0] e;
      bus_q.delete();
      exp_q.delete();
      issue_start(p);
      vectors++;
      if ({f_wen, f_cle, f_ale, busy, f_io} !== {4'b0101, 8'h00}) begin
         errors++;
         $display("FAIL cmd_timing p%0d got wen/cle/ale/busy=%b io=%h want 0101 00", p,
                  {f_wen, f_cle, f_ale, busy}, f_io);
      end
      collect(stall_at, 10, start_at, -1, n_done, stall_bad, to);
      vectors++;
      if (to || n_done != 1) begin errors++; $display("FAIL done_p%0d timeout=%0d want 0", p, to); end
      vectors++;
      if (bus_q.size() != 4 || bus_q[0] !== 10'h200 || bus_q[1] !== 10'h100 ||
          bus_q[2] !== {2'b01, 8'(p)} || bus_q[3] !== {2'b01, 7'b0, 1'(p >> 8)}) begin
         errors++;
         $display("FAIL addr_p%0d got %0d writes %p want 200 100 %h %h", p, bus_q.size(),
                  bus_q, {2'b01, 8'(p)}, {2'b01, 7'b0, 1'(p >> 8)});
      end
      vectors++;
      if (obs_data.size() != 512) begin
         errors++; $display("FAIL count_p%0d got %0d want 512", p, obs_data.size());
      end
      nlast = 0;
      for (int i = 0; i < obs_data.size() && exp_q.size() > 0; i++) begin
         e = exp_q.pop_front();
         vectors++;
         if (obs_data[i] !== e) begin
            errors++; $display("FAIL data_p%0d[%0d] got %h want %h", p, i, obs_data[i], e);
         end
         if (obs_last[i]) nlast++;
      end
      vectors++;
      if (nlast != 1 || obs_last.size() != 512 || obs_last[511] !== 1'b1) begin
         errors++; $display("FAIL last_p%0d got %0d flags want 1 on byte 511", p, nlast);
      end
      if (stall_at >= 0) begin
         vectors++;
         if (stall_bad != 0) begin
            errors++; $display("FAIL hold_p%0d got %0d unstable cycles want 0", p, stall_bad);
         end
      end
      @(negedge clk);
      vectors++;
      if (page_done !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL done_pulse_p%0d got done=%b busy=%b want 0 0", p,
                            page_done, busy);
      end
   endtask

   task automatic test_reset_midpage();
      int n_done, stall_bad, cycles; bit to, pd;
      exp_q.delete();
      issue_start(2);
      collect(-1, 0, -1, 100, n_done, stall_bad, to);
      bus_q.delete();
      @(negedge clk);
      vectors++;
      if ({f_cle, f_ale, f_ren, f_wen, busy, rd_valid, rd_last, page_done, rd_data} !==
          {8'b0011_1000, 8'h00})
         begin errors++; $display("FAIL midpage_reset got %b", {f_cle, f_ale, f_ren, f_wen,
                busy, rd_valid, rd_last, page_done, rd_data}); end
      vectors++;
      if (n_done != 0 || to) begin errors++; $display("FAIL midpage_done got %0d want 0", n_done); end
      rst = 1'b0;
      exp_q.delete();
      wait_idle(cycles, pd);
      vectors++;
      if (pd || bus_q.size() != 1 || bus_q[0] !== 10'h2FF) begin
         errors++;
         $display("FAIL midpage_init got pd=%0d writes=%0d want pd=0 one 2ff", pd, bus_q.size());
      end
      test_page(3, -1, -1);
   endtask

   initial begin
      test_reset();
      test_page(0, -1, -1);
      test_page(257, -1, -1);
      test_page(1, 5, -1);           // backpressure at byte 5
      test_page(7, -1, 50);          // stray start during streaming
      test_page(9, -1, -1);          // start right after page_done
      test_reset_midpage();
      vectors++;
      if (viol != 0) begin errors++; $display("FAIL strobe_overlap got %0d want 0", viol); end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/nfc_page_reader.md
# nfc_page_reader

Source-side read engine of the NAND flash copy controller. It resets flash A, then on each request issues a READ (0x00) command plus three address cycles for one 512-byte page, waits for ready/busy, and streams the page out one byte at a time over a valid/ready handshake. The page-program stage that writes flash B consumes this stream.

## Interface
Parameters:
- PAGE_BITS, 9: page-address width (512 pages × 512 B = 262144 B).
- PAGE_SIZE, 512: bytes per page.
- TWB_CYCLES, 2: cycles after the last address WEN rise during which F_RB_A is ignored.

Ports:
- clk  in  1  system clock. One clock domain; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- start  in  1  page-read request; sampled only while busy=0.
- page_addr  in  PAGE_BITS  page to read; captured on the accepted start edge.
- busy  out  1  engine not able to accept start.
- rd_data  out  8  page byte.
- rd_valid  out  1  rd_data valid.
- rd_ready  in  1  consumer accepts byte (transfer = rd_valid & rd_ready at clk edge).
- rd_last  out  1  high with byte PAGE_SIZE-1.
- page_done  out  1  one-cycle pulse after the last byte transfers.
- F_IO_A  inout  8  flash data bus; driven only in command/address states, else hi-Z.
- F_CLE_A, F_ALE_A  out  1  command / address latch enables.
- F_REN_A, F_WEN_A  out  1  active-low read / write strobes.
- F_RB_A  in  1  flash ready (1) / busy (0).

## Operation
- States: INIT_CMD, INIT_WAIT, IDLE, CMD, ADDR0, ADDR1, ADDR2, WAIT_TWB, WAIT_RB, RD_LO, RD_HI, HOLD, DONE.
- Bus write cycle (command or address) takes 2 clk cycles: WEN=0 with IO driven, then WEN=1 with IO and CLE/ALE held. The flash latches on the WEN rising edge.
- After rst: INIT_CMD writes 0xFF with CLE=1, then TWB_CYCLES of waiting, then INIT_WAIT until F_RB_A=1, then IDLE. busy=1 throughout.
- IDLE: busy=0. start=1 latches page_addr and moves to CMD. busy=1 from the next cycle.
- CMD writes 0x00 (CLE=1).
- ADDR0 writes column 0x00. ADDR1 writes page_addr[7:0]. ADDR2 writes {7'b0, page_addr[8]}. All with ALE=1.
- WAIT_TWB ignores F_RB_A for TWB_CYCLES cycles. WAIT_RB then waits for F_RB_A=1. There is no timeout.
- Byte read:
  - RD_LO holds REN=0 for 2 cycles.
  - F_IO_A is captured into rd_data on the edge ending the 2nd low cycle. The same edge enters RD_HI with REN=1 and rd_valid=1.
  - If rd_ready=1 in RD_HI, the byte transfers and the next RD_LO follows.
  - If rd_ready=0, the engine moves to HOLD: REN stays 1, and rd_data/rd_valid are held stable until the transfer.
- Byte counter is 10 bits and resets to 0 at CMD. rd_last = (count == PAGE_SIZE-1) while rd_valid.
- The transfer of the last byte enters DONE: page_done=1 for one cycle, then IDLE.
- start while busy=1 is ignored and not queued.
- CLE and ALE are never high together. REN and WEN are never low together.

## Timing
- Reset values: F_CLE_A=0, F_ALE_A=0, F_REN_A=1, F_WEN_A=1, F_IO_A=Z, busy=1, rd_valid=0, rd_last=0, page_done=0, rd_data=0x00.
- rst asserted in any state (including mid-page) returns all outputs to reset values on the next edge and restarts at INIT_CMD. Any partially streamed page is abandoned, with no page_done.
- start accepted at edge t → first WEN low in cycle t+1. The 4 write cycles occupy t+1..t+8. WAIT_TWB covers t+9..t+10.
- From F_RB_A=1 seen in WAIT_RB: first rd_valid 3 cycles later. Steady state with rd_ready=1 is 3 cycles/byte, so a page takes 1536 cycles plus overhead.
- rd_valid never drops without a transfer (except on rst).

## Test plan
- Reset: pulse rst → F_IO_A=0xFF is written with CLE=1, then one WEN rise. busy stays 1 until F_RB_A=1, then busy=0. All strobes sit at their idle values.
- Read page 0, rd_ready=1: the bus shows the sequence 0x00(CLE), then 0x00, 0x00, 0x00 (ALE). Exactly 512 bytes equal flash A Mem[0..511]. rd_last appears only on byte 511, followed by a one-cycle page_done pulse.
- Read page 257: address bytes are 0x00, 0x01, 0x01. Output matches Mem[131584..132095].
- Backpressure: hold rd_ready=0 for 10 cycles at byte 5 → rd_data is stable and REN stays 1 during the hold. No byte is lost or duplicated, and the count is 512.
- start pulsed during streaming: ignored, so page_addr changes have no effect and the stream is unchanged. A start after page_done is accepted.
- rst at byte 100: outputs go to reset values on the next edge and the 0xFF init sequence repeats. No page_done is seen. A subsequent read of page 3 completes correctly.
